// File: rtl/resample_pkg.sv
// Types and helpers shared by the dsp/resample blocks (upsampler, downsampler).
package resample_pkg;

    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE,
        EMIT
    } upsampler_state_t;

endpackage

// File: rtl/upsampler.sv
// Interpolation-by-L expander: one sample in, L beats out (zero-stuffed).
// Define UPSAMPLER_ZERO_ORDER_HOLD_EN to repeat the held sample on phases 1..L-1.
module upsampler
    import resample_pkg::*;
#(
    parameter int data_width_p     = -1,
    parameter int interpolation_L_p = -1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [data_width_p-1:0] x,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [data_width_p-1:0] y,
    output logic                    y_first
);

    if (data_width_p < 1) begin : g_bad_width
        $error("upsampler: data_width_p must be >= 1");
    end
    if (interpolation_L_p < 2) begin : g_bad_factor
        $error("upsampler: interpolation_L_p must be >= 2");
    end

    localparam int              PW   = phase_width(interpolation_L_p);
    localparam logic [PW-1:0]   LAST = PW'(interpolation_L_p - 1);

    upsampler_state_t          r_state, w_state_nxt;
    logic [PW-1:0]             r_phase, w_phase_nxt;
    logic [data_width_p-1:0]   r_hold,  w_hold_nxt;
    logic [data_width_p-1:0]   r_y,     w_y_nxt;
    logic                      r_y_valid, w_y_valid_nxt;
    logic                      r_y_first, w_y_first_nxt;

    logic                      w_last;
    logic                      w_x_ready_core;
    logic                      w_accept;
    logic                      w_y_xfer;
    logic [data_width_p-1:0]   w_fill;

    assign w_last   = (r_phase == LAST);
    assign w_y_xfer = r_y_valid & y_ready;

    // Ready is combinational from y_ready so the last beat and the next sample
    // can hand off in the same cycle; rst_n only gates the visible port.
    assign w_x_ready_core = (r_state == IDLE) | ((r_state == EMIT) & w_last & y_ready);
    assign x_ready        = rst_n & w_x_ready_core;
    assign w_accept       = x_valid & w_x_ready_core;

`ifdef UPSAMPLER_ZERO_ORDER_HOLD_EN
    assign w_fill = r_hold;
`else
    assign w_fill = '0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_hold_nxt    = r_hold;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_y_first_nxt = r_y_first;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = EMIT;
                    w_phase_nxt   = '0;
                    w_hold_nxt    = x;
                    w_y_nxt       = x;
                    w_y_valid_nxt = 1'b1;
                    w_y_first_nxt = 1'b1;
                end
            end
            EMIT: begin
                if (w_y_xfer) begin
                    if (!w_last) begin
                        w_phase_nxt   = r_phase + PW'(1);
                        w_y_nxt       = w_fill;
                        w_y_first_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_phase_nxt   = '0;
                        w_hold_nxt    = x;
                        w_y_nxt       = x;
                        w_y_first_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_phase_nxt   = '0;
                        w_y_nxt       = '0;
                        w_y_valid_nxt = 1'b0;
                        w_y_first_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_phase_nxt   = '0;
                w_y_nxt       = '0;
                w_y_valid_nxt = 1'b0;
                w_y_first_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_hold    <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_first <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_hold    <= w_hold_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_y_first <= w_y_first_nxt;
        end
    end

    assign y_valid = r_y_valid;
    assign y       = r_y;
    assign y_first = r_y_first;

endmodule

// File: tb/tb_upsampler.sv
// Self-checking bench for upsampler: L=4/W=16 and L=2/W=8 instances against a beat-queue model.
module tb_upsampler;

    localparam int LA = 4;
    localparam int LB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_x_valid = 1'b0, a_x_ready, a_y_valid, a_y_ready = 1'b0, a_y_first;
    logic [15:0] a_x = '0, a_y;
    logic        b_x_valid = 1'b0, b_x_ready, b_y_valid, b_y_ready = 1'b0, b_y_first;
    logic [7:0]  b_x = '0, b_y;

    upsampler #(.data_width_p(16), .interpolation_L_p(LA)) u_a (
        .clk(clk), .rst_n(rst_n),
        .x_valid(a_x_valid), .x_ready(a_x_ready), .x(a_x),
        .y_valid(a_y_valid), .y_ready(a_y_ready), .y(a_y), .y_first(a_y_first)
    );

    upsampler #(.data_width_p(8), .interpolation_L_p(LB)) u_b (
        .clk(clk), .rst_n(rst_n),
        .x_valid(b_x_valid), .x_ready(b_x_ready), .x(b_x),
        .y_valid(b_y_valid), .y_ready(b_y_ready), .y(b_y), .y_first(b_y_first)
    );

    typedef struct {
        logic        first;
        logic [15:0] d;
    } beat_t;

    // Pending output beats each DUT still owes, in order.
    beat_t qa[$];
    beat_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] fill_of(input logic [15:0] s);
`ifdef UPSAMPLER_ZERO_ORDER_HOLD_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic push_a(input logic [15:0] s);
        for (int p = 0; p < LA; p++) begin
            beat_t b;
            b.first = (p == 0);
            b.d     = (p == 0) ? s : fill_of(s);
            qa.push_back(b);
        end
    endtask

    task automatic push_b(input logic [15:0] s);
        for (int p = 0; p < LB; p++) begin
            beat_t b;
            b.first = (p == 0);
            b.d     = (p == 0) ? s : fill_of(s);
            qb.push_back(b);
        end
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic r);
        a_x_valid = v; a_x = d; a_y_ready = r;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] d, input logic r);
        b_x_valid = v; b_x = d; b_y_ready = r;
        #1;
    endtask

    task automatic tick_a(output bit acc, output bit xf);
        logic [15:0] xs;
        acc = a_x_valid && a_x_ready;
        xf  = a_y_valid && a_y_ready;
        xs  = a_x;
        @(negedge clk);
        if (xf && qa.size() != 0) void'(qa.pop_front());
        if (acc) push_a(xs);
    endtask

    task automatic tick_b(output bit acc, output bit xf);
        logic [15:0] xs;
        acc = b_x_valid && b_x_ready;
        xf  = b_y_valid && b_y_ready;
        xs  = {8'h00, b_x};
        @(negedge clk);
        if (xf && qb.size() != 0) void'(qb.pop_front());
        if (acc) push_b(xs);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_x_valid = 1'b1; b_x_valid = 1'b1;
        #1;
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_y_valid got %b want 0", a_y_valid); end
        n_checks++; if (a_y !== 16'h0000) begin n_fail++; $display("FAIL reset_a_y got %h want 0000", a_y); end
        n_checks++; if (a_y_first !== 1'b0) begin n_fail++; $display("FAIL reset_a_y_first got %b want 0", a_y_first); end
        n_checks++; if (a_x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_x_ready got %b want 0", a_x_ready); end
        n_checks++; if (b_y_valid !== 1'b0 || b_y !== 8'h00 || b_x_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_b got valid=%b y=%h rdy=%b want 0 00 0", b_y_valid, b_y, b_x_ready);
        end
        a_x_valid = 1'b0; b_x_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_x_ready !== 1'b1) begin n_fail++; $display("FAIL idle_a_x_ready got %b want 1", a_x_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc, xf;
        int beats = 0;
        for (int c = 0; c < 8; c++) begin
            drive_a(c == 0, 16'h1234, 1'b1);
            n_checks++; if (a_x_ready !== ((qa.size() == 0) || (qa.size() == 1 && a_y_ready))) begin
                n_fail++; $display("FAIL single_x_ready c=%0d got %b", c, a_x_ready); end
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL single_y_valid c=%0d got %b want %b", c, a_y_valid, qa.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (a_y !== qa[0].d || a_y_first !== qa[0].first) begin
                    n_fail++; $display("FAIL single_beat c=%0d got %h/%b want %h/%b", c, a_y, a_y_first, qa[0].d, qa[0].first); end
            end else begin
                n_checks++; if (a_y !== 16'h0000) begin n_fail++; $display("FAIL single_idle_y c=%0d got %h want 0000", c, a_y); end
            end
            tick_a(acc, xf);
            if (xf) beats++;
        end
        n_checks++; if (beats != LA) begin n_fail++; $display("FAIL single_beat_count got %0d want %0d", beats, LA); end
    endtask

    task automatic test_back_to_back();
        bit acc, xf;
        int idx = 0, beats = 0, accepts = 0;
        for (int c = 0; c < 16; c++) begin
            drive_a(idx < 3, 16'(idx + 1), 1'b1);
            n_checks++; if (a_x_ready !== ((qa.size() == 0) || (qa.size() == 1 && a_y_ready))) begin
                n_fail++; $display("FAIL b2b_x_ready c=%0d got %b", c, a_x_ready); end
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL b2b_y_valid c=%0d got %b want %b", c, a_y_valid, qa.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (a_y !== qa[0].d || a_y_first !== qa[0].first) begin
                    n_fail++; $display("FAIL b2b_beat c=%0d got %h/%b want %h/%b", c, a_y, a_y_first, qa[0].d, qa[0].first); end
            end
            tick_a(acc, xf);
            if (acc) begin idx++; accepts++; end
            if (xf) beats++;
            // Contiguous stream: all twelve beats are out by cycle 12.
            if (c == 12) begin
                n_checks++; if (beats != 3 * LA) begin n_fail++; $display("FAIL b2b_contiguous got %0d want %0d", beats, 3 * LA); end
            end
        end
        n_checks++; if (accepts != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", accepts); end
    endtask

    task automatic test_backpressure();
        bit acc, xf;
        bit sent = 0;
        int stalls = 0;
        for (int c = 0; c < 16; c++) begin
            logic r;
            r = 1'b1;
            if (sent && qa.size() == 2 && stalls < 3) begin r = 1'b0; stalls++; end
            drive_a(!sent, 16'h0055, r);
            n_checks++; if (a_x_ready !== ((qa.size() == 0) || (qa.size() == 1 && a_y_ready))) begin
                n_fail++; $display("FAIL bp_x_ready c=%0d got %b", c, a_x_ready); end
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL bp_y_valid c=%0d got %b want %b", c, a_y_valid, qa.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (a_y !== qa[0].d || a_y_first !== qa[0].first) begin
                    n_fail++; $display("FAIL bp_beat c=%0d got %h/%b want %h/%b", c, a_y, a_y_first, qa[0].d, qa[0].first); end
            end
            tick_a(acc, xf);
            if (acc) sent = 1;
        end
    endtask

    task automatic test_reset_mid();
        bit acc, xf;
        for (int c = 0; c < 6; c++) begin
            drive_a(c == 0, 16'hAAAA, 1'b1);
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL rmid_pre_y_valid c=%0d got %b", c, a_y_valid); end
            tick_a(acc, xf);
            if (qa.size() == 2) break;
        end
        a_x_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        qa.delete();
        n_checks++; if (a_y_valid !== 1'b0 || a_y !== 16'h0000 || a_y_first !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async got %b/%h/%b want 0/0000/0", a_y_valid, a_y, a_y_first); end
        n_checks++; if (a_x_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_x_ready got %b want 0", a_x_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive_a(c == 0, 16'h7FFF, 1'b1);
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL rmid_y_valid c=%0d got %b want %b", c, a_y_valid, qa.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (a_y !== qa[0].d || a_y_first !== qa[0].first) begin
                    n_fail++; $display("FAIL rmid_beat c=%0d got %h/%b want %h/%b", c, a_y, a_y_first, qa[0].d, qa[0].first); end
            end else begin
                n_checks++; if (a_y !== 16'h0000) begin n_fail++; $display("FAIL rmid_idle_y c=%0d got %h", c, a_y); end
            end
            tick_a(acc, xf);
        end
    endtask

    task automatic test_l2();
        bit acc, xf;
        logic [7:0] vals [6];
        int idx = 0, beats = 0;
        vals[0] = 8'hAB; vals[1] = 8'hCD;
        for (int i = 2; i < 6; i++) vals[i] = 8'($urandom);
        for (int c = 0; c < 16; c++) begin
            drive_b(idx < 6, (idx < 6) ? vals[idx] : 8'h00, 1'b1);
            n_checks++; if (b_x_ready !== ((qb.size() == 0) || (qb.size() == 1 && b_y_ready))) begin
                n_fail++; $display("FAIL l2_x_ready c=%0d got %b", c, b_x_ready); end
            n_checks++; if (b_y_valid !== (qb.size() != 0)) begin
                n_fail++; $display("FAIL l2_y_valid c=%0d got %b want %b", c, b_y_valid, qb.size() != 0); end
            if (qb.size() != 0) begin
                n_checks++; if (b_y !== qb[0].d[7:0] || b_y_first !== qb[0].first) begin
                    n_fail++; $display("FAIL l2_beat c=%0d got %h/%b want %h/%b", c, b_y, b_y_first, qb[0].d[7:0], qb[0].first); end
            end else begin
                n_checks++; if (b_y !== 8'h00) begin n_fail++; $display("FAIL l2_idle_y c=%0d got %h", c, b_y); end
            end
            tick_b(acc, xf);
            if (acc) idx++;
            if (xf) beats++;
        end
        n_checks++; if (beats != 6 * LB) begin n_fail++; $display("FAIL l2_beat_count got %0d want %0d", beats, 6 * LB); end
    endtask

    task automatic test_random();
        bit acc, xf;
        for (int c = 0; c < 320; c++) begin
            logic v, r;
            v = (c < 300) ? 1'($urandom) : 1'b0;
            r = (c < 300) ? (($urandom % 4) != 0) : 1'b1;
            drive_a(v, 16'($urandom), r);
            n_checks++; if (a_x_ready !== ((qa.size() == 0) || (qa.size() == 1 && a_y_ready))) begin
                n_fail++; $display("FAIL rnd_x_ready c=%0d got %b", c, a_x_ready); end
            n_checks++; if (a_y_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL rnd_y_valid c=%0d got %b want %b", c, a_y_valid, qa.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (a_y !== qa[0].d || a_y_first !== qa[0].first) begin
                    n_fail++; $display("FAIL rnd_beat c=%0d got %h/%b want %h/%b", c, a_y, a_y_first, qa[0].d, qa[0].first); end
            end
            tick_a(acc, xf);
        end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending want 0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_l2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
